// File: rtl/rs_syndrome.sv
// ---------------------------------------------------------------------------
// rs_syndrome
//   Front stage of the RS decoder. Consumes a serial codeword stream, one
//   m-bit symbol per accepted cycle with the highest-degree coefficient first.
//   It evaluates the received polynomial at the `check` generator roots using
//   one Horner accumulator per root. At end of frame it publishes the syndrome
//   vector with a one-cycle strobe, an any-nonzero flag and a frame-length
//   error flag.
//
// Ports:
//   iclk           clock
//   ireset         synchronous active-high reset (takes effect when iclkena=1)
//   iclkena        clock enable; low freezes all state and outputs
//   isop           first symbol of a codeword (qualified by ival)
//   ival           symbol valid
//   ieop           last symbol of a codeword (qualified by ival)
//   idat           received symbol
//   osyndrome_val  one-cycle strobe: syndrome vector complete
//   osyndrome      S_j at bits [j*m +: m]
//   oerr           OR of all S_j, held until the next end of frame
//   osize_err      received length != n, held until the next end of frame
//
// Stream semantics: a symbol is accepted on a rising iclk edge when
// iclkena=1 and ival=1. isop and ieop are looked at only for accepted
// symbols. There is no back-pressure: every accepted symbol is consumed.
// ---------------------------------------------------------------------------
module rs_syndrome #(
    parameter int n         = 255,
    parameter int check     = 30,
    parameter int m         = 8,
    parameter int irrpol    = 285,
    parameter int genstart  = 0,
    parameter int rootspace = 1
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               isop,
    input  logic               ival,
    input  logic               ieop,
    input  logic [m-1:0]       idat,
    output logic               osyndrome_val,
    output logic [check*m-1:0] osyndrome,
    output logic               oerr,
    output logic               osize_err
);

    // The counter holds values up to n+1. Saturating at n+1 keeps over-length
    // frames distinguishable from exact-length ones.
    localparam int             CW      = $clog2(n + 2);
    localparam logic [CW-1:0]  CNT_N   = CW'(n);
    localparam logic [CW-1:0]  CNT_SAT = CW'(n + 1);
    // The top bit of the field polynomial is implied by the shift-out.
    localparam logic [m-1:0]   POLY    = m'(irrpol);

    function automatic logic [m-1:0] gf_mult(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] p;
        logic [m-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < m; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[m-2:0], 1'b0} ^ (aa[m-1] ? POLY : '0);
        end
        return p;
    endfunction

    // root_j = alpha^((genstart + j*rootspace) mod (2^m-1)), packed like osyndrome.
    function automatic logic [check*m-1:0] gen_roots();
        logic [check*m-1:0] v;
        logic [m-1:0]       r;
        v = '0;
        for (int j = 0; j < check; j++) begin
            r = m'(1);
            for (int e = 0; e < (genstart + j * rootspace) % ((1 << m) - 1); e++)
                r = gf_mult(r, m'(2));
            v[j*m +: m] = r;
        end
        return v;
    endfunction

    localparam logic [check*m-1:0] ROOTS = gen_roots();

    logic [check*m-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               in_frame_q, in_frame_d;
    logic [check*m-1:0] syn_q, syn_d;
    logic               err_q, err_d;
    logic               size_err_q, size_err_d;
    logic               val_q, val_d;
    logic               take;

    // A symbol joins a frame if it opens one or arrives while one is open.
    // An isop always restarts, which silently drops any unfinished frame.
    assign take = ival & (isop | in_frame_q);

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        in_frame_d = in_frame_q;
        syn_d      = syn_q;
        err_d      = err_q;
        size_err_d = size_err_q;
        val_d      = 1'b0;
        if (take) begin
            for (int j = 0; j < check; j++) begin
                acc_d[j*m +: m] = isop ? idat
                                       : (gf_mult(acc_q[j*m +: m], ROOTS[j*m +: m]) ^ idat);
            end
            if (isop)                  cnt_d = CW'(1);
            else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
            in_frame_d = ~ieop;
            // Publish the accumulators including this last symbol.
            if (ieop) begin
                syn_d      = acc_d;
                err_d      = |acc_d;
                size_err_d = (cnt_d != CNT_N);
                val_d      = 1'b1;
            end
        end
    end

    // A disabled cycle holds everything, including an asserted strobe.
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (ireset) begin
                acc_q      <= '0;
                cnt_q      <= '0;
                in_frame_q <= 1'b0;
                syn_q      <= '0;
                err_q      <= 1'b0;
                size_err_q <= 1'b0;
                val_q      <= 1'b0;
            end else begin
                acc_q      <= acc_d;
                cnt_q      <= cnt_d;
                in_frame_q <= in_frame_d;
                syn_q      <= syn_d;
                err_q      <= err_d;
                size_err_q <= size_err_d;
                val_q      <= val_d;
            end
        end
    end

    assign osyndrome_val = val_q;
    assign osyndrome     = syn_q;
    assign oerr          = err_q;
    assign osize_err     = size_err_q;

endmodule

// File: tb/tb_rs_syndrome.sv
module tb_rs_syndrome;

  localparam int N = 255;
  localparam int CHECK = 30;
  localparam int M = 8;
  localparam int W = CHECK * M + 2;   // {size_err, err, syndrome}

  logic                 iclk;
  logic                 ireset;
  logic                 iclkena;
  logic                 isop;
  logic                 ival;
  logic                 ieop;
  logic [M-1:0]         idat;
  logic                 osyndrome_val;
  logic [CHECK*M-1:0]   osyndrome;
  logic                 oerr;
  logic                 osize_err;

  rs_syndrome #(
    .n(N), .check(CHECK), .m(M), .irrpol(285), .genstart(0), .rootspace(1)
  ) dut (
    .iclk(iclk),
    .ireset(ireset),
    .iclkena(iclkena),
    .isop(isop),
    .ival(ival),
    .ieop(ieop),
    .idat(idat),
    .osyndrome_val(osyndrome_val),
    .osyndrome(osyndrome),
    .oerr(oerr),
    .osize_err(osize_err)
  );

  // ---------------- clock ----------------
  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  // ---------------- counters / scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_last = '0;
  logic         exp_val = 1'b0;
  logic         want_clean = 1'b0;

  logic [7:0]   frame_q[$];      // symbols of the frame the model sees open
  logic         in_frame_m = 1'b0;
  logic [7:0]   tx_q[$];         // symbols the driver sends next

  // ---------------- GF(256) tables, field polynomial 0x11D ----------------
  logic [7:0] exp_t[0:254];
  int         log_t[0:255];
  logic [7:0] g[0:30];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic init_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = i;
      x = x << 1;
      if (x >= 256) x = x ^ 285;
    end
    log_t[0] = 0;
    // g(x) = prod_{j=0}^{29} (x + alpha^j), g[k] is the coefficient of x^k
    for (int k = 0; k <= 30; k++) g[k] = 8'h00;
    g[0] = 8'h01;
    for (int r = 0; r < CHECK; r++) begin
      for (int k = r + 1; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], exp_t[r]);
      g[0] = gf_mul(g[0], exp_t[r]);
    end
  endtask

  // Direct polynomial evaluation: S_j = sum_i r_i * (alpha^j)^deg_i
  function automatic logic [W-1:0] model_result();
    logic [CHECK*M-1:0] syn;
    logic [7:0]         s;
    int                 len;
    len = frame_q.size();
    syn = '0;
    for (int j = 0; j < CHECK; j++) begin
      s = 8'h00;
      for (int i = 0; i < len; i++)
        s = s ^ gf_mul(frame_q[i], exp_t[(j * (len - 1 - i)) % 255]);
      syn[j*M +: M] = s;
    end
    return {(len != N), (syn != '0), syn};
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, advance the model, check at the falling edge.
  task automatic cycle(input logic ena, input logic rst, input logic val,
                       input logic sop, input logic eop, input logic [7:0] dat);
    logic new_strobe;
    iclkena = ena; ireset = rst; ival = val; isop = sop; ieop = eop; idat = dat;
    new_strobe = 1'b0;
    if (ena) begin
      if (rst) begin
        in_frame_m = 1'b0;
        frame_q.delete();
        exp_q.delete();
        exp_val = 1'b0;
        exp_last = '0;
      end else begin
        exp_val = 1'b0;
        if (val && (sop || in_frame_m)) begin
          if (sop) frame_q.delete();
          frame_q.push_back(dat);
          in_frame_m = 1'b1;
          if (eop) begin
            exp_q.push_back(model_result());
            exp_val = 1'b1;
            new_strobe = 1'b1;
            in_frame_m = 1'b0;
          end
        end
      end
    end
    @(posedge iclk);
    @(negedge iclk);
    if (new_strobe) exp_last = exp_q.pop_front();
    check_eq("val", 256'(osyndrome_val), 256'(exp_val));
    check_eq("out", 256'({osize_err, oerr, osyndrome}), 256'(exp_last));
    if (new_strobe && want_clean)
      check_eq("cw_clean", 256'({osize_err, oerr}), 256'(0));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input bit gaps, input bit tog, input bit with_eop);
    for (int i = 0; i < tx_q.size(); i++) begin
      bit   done;
      int   tries;
      logic ena;
      done = 0;
      tries = 0;
      while (!done) begin
        ena = (tog && tries < 20) ? ($urandom_range(0, 3) != 0) : 1'b1;
        tries++;
        if (gaps && tries < 20 && $urandom_range(0, 4) == 0)
          cycle(ena, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
        else begin
          cycle(ena, 1'b0, 1'b1, (i == 0), (with_eop && i == tx_q.size() - 1), tx_q[i]);
          done = ena;
        end
      end
    end
  endtask

  task automatic set_zero(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'h00);
  endtask

  task automatic set_rand(input int len);
    tx_q.delete();
    for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Systematic codeword: 225 random data symbols then the 30 remainder symbols.
  task automatic make_codeword();
    logic [7:0] rem[0:29];
    logic [7:0] d;
    logic [7:0] fb;
    tx_q.delete();
    for (int i = 0; i < CHECK; i++) rem[i] = 8'h00;
    for (int k = 0; k < N - CHECK; k++) begin
      d = 8'($urandom_range(0, 255));
      fb = d ^ rem[CHECK-1];
      for (int i = CHECK - 1; i >= 1; i--) rem[i] = rem[i-1] ^ gf_mul(fb, g[i]);
      rem[0] = gf_mul(fb, g[0]);
      tx_q.push_back(d);
    end
    for (int i = CHECK - 1; i >= 0; i--) tx_q.push_back(rem[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CHECK*M-1:0] all5;
    int                 kind;
    int                 pos;
    iclkena = 1'b0; ireset = 1'b0; ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = '0;
    init_tables();
    all5 = {CHECK{8'h05}};
    @(negedge iclk);

    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("reset_out", 256'({osyndrome_val, osize_err, oerr, osyndrome}), 256'(0));
    idle(2);

    // all-zero full-length frame
    set_zero(N);
    send_frame(0, 0, 1);
    check_eq("t1_syn", 256'({osyndrome_val, osize_err, oerr, osyndrome}), 256'({1'b1, 2'b00}) << (CHECK*M));
    idle(3);

    // last symbol 0x05: every S_j is the constant term
    set_zero(N);
    tx_q[N-1] = 8'h05;
    send_frame(0, 0, 1);
    check_eq("t2_syn", 256'(osyndrome), 256'(all5));
    check_eq("t2_flags", 256'({osize_err, oerr}), 256'(2'b01));
    idle(2);

    // r(x) = x, so S_j = alpha^j
    set_zero(N);
    tx_q[253] = 8'h01;
    send_frame(0, 0, 1);
    check_eq("t3_s0", 256'(osyndrome[7:0]), 256'(8'h01));
    check_eq("t3_s1", 256'(osyndrome[15:8]), 256'(8'h02));
    check_eq("t3_s2", 256'(osyndrome[23:16]), 256'(8'h04));
    check_eq("t3_s7", 256'(osyndrome[63:56]), 256'(8'h80));
    check_eq("t3_s8", 256'(osyndrome[71:64]), 256'(8'h1D));
    check_eq("t3_err", 256'(oerr), 256'(1));
    idle(2);

    // two valid codewords, the second starting right after the first ends
    want_clean = 1'b1;
    make_codeword();
    send_frame(1, 1, 1);
    make_codeword();
    send_frame(0, 0, 1);
    want_clean = 1'b0;
    idle(2);

    // short frame, then a frame interrupted by a restart
    set_rand(200);
    send_frame(1, 0, 1);
    check_eq("t5_size", 256'(osize_err), 256'(1));
    set_rand(80);
    send_frame(0, 0, 0);
    set_rand(N);
    send_frame(1, 1, 1);
    check_eq("t5_restart_size", 256'(osize_err), 256'(0));
    idle(2);

    // reset in the middle of a frame
    set_rand(100);
    send_frame(0, 0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    check_eq("t6_reset_out", 256'({osyndrome_val, osize_err, oerr, osyndrome}), 256'(0));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44);   // stray eop outside a frame
    set_zero(N);
    send_frame(0, 0, 1);
    check_eq("t6_err", 256'(oerr), 256'(0));
    idle(2);

    // randomized frames: odd lengths, corrupted codewords, over-length
    for (int f = 0; f < 10; f++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: set_rand(1);
        1: set_rand(254);
        2: set_rand(256);
        3: set_rand(300);
        4: begin
          make_codeword();
          for (int e = 0; e < 3; e++) begin
            pos = $urandom_range(0, N - 1);
            tx_q[pos] = tx_q[pos] ^ 8'($urandom_range(1, 255));
          end
        end
        default: make_codeword();
      endcase
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_syndrome.md
Name: rs_syndrome

Overview:
- Decoder front stage for the RS codec: consumes a serial codeword stream (data + check symbols), one m-bit symbol per valid cycle.
- Computes the `check` syndromes S_j = r(alpha^(genstart + j*rootspace)), j = 0..check-1, using parallel Horner accumulators.
- Presents the complete syndrome vector with a one-cycle strobe, an error flag and a frame-length-error flag to the downstream key-equation solver.
- Sits directly downstream of the encoder / channel and uses the same GF parameter set and GF function includes.

Parameters:
- n, 255, codeword length in symbols.
- check, 30, number of check symbols (= number of syndromes).
- m, 8, symbol width in bits.
- irrpol, 285, GF(2^m) field polynomial.
- genstart, 0, first root exponent of the generator polynomial.
- rootspace, 1, exponent step between consecutive roots.

Ports:
- iclk  in  1  clock.
- ireset  in  1  reset; synchronous, active-high.
- iclkena  in  1  clock enable; low freezes all state and outputs.
- isop  in  1  first symbol of codeword, qualified by ival.
- ival  in  1  symbol valid.
- ieop  in  1  last symbol of codeword, qualified by ival.
- idat  in  m  received symbol, highest-degree coefficient first.
- osyndrome_val  out  1  one-cycle strobe: syndrome vector complete.
- osyndrome  out  check*m  S_j at bits [j*m +: m].
- oerr  out  1  any S_j nonzero; valid with osyndrome_val, held after it.
- osize_err  out  1  received frame length != n; valid with osyndrome_val, held after it.

Behaviour:
- Reset (ireset=1 at a rising iclk edge with iclkena=1): all accumulators, the symbol counter, the in-frame flag and all outputs are cleared to 0. A reset mid-frame discards that frame; no strobe is produced for it.
- Root constants: root_j = alpha^((genstart + j*rootspace) mod (2^m-1)), computed at elaboration via the GF functions. Multiplication by root_j is a constant GF multiply.
- Per accepted symbol (iclkena & ival):
  - isop=1: acc_j <= idat for all j; cnt <= 1; in_frame <= 1. This overrides any frame in progress (restart; the old frame is dropped silently).
  - isop=0, in_frame=1: acc_j <= gf_mult(acc_j, root_j) ^ idat; cnt <= cnt + 1, saturating at n+1.
  - isop=0, in_frame=0: symbol ignored.
- End of frame: an accepted symbol with ieop=1 that is either in-frame or carries isop.
  - The updated accumulator values (including this symbol) are written to osyndrome on the same edge.
  - osyndrome_val=1 for exactly that next cycle.
  - oerr = OR of the new syndromes.
  - osize_err = (final count != n).
  - in_frame <= 0.
- isop & ieop in the same cycle: one-symbol frame; S_j = idat; osize_err=1 unless n=1.
- Latency: strobe appears 1 cycle after the ieop symbol is sampled. Back-to-back frames are supported: isop may arrive in the cycle immediately after ieop, with zero idle cycles and no throughput loss.
- Output holding: osyndrome, oerr and osize_err keep their values until the next end-of-frame; osyndrome_val is 0 otherwise.
- Counter: ceil(log2(n+2)) bits, saturating, so no wrap on over-length frames.
- ival=0 cycles inside a frame are gaps; state is held.
- iclkena=0: everything holds, including an active osyndrome_val, which stays asserted until the next enabled cycle.

Test Plan:
- Reset, then a 255-symbol all-zero frame -> one strobe 1 cycle after ieop; osyndrome=0, oerr=0, osize_err=0.
- Frame of 254 zeros, last symbol 0x05 -> all 30 S_j=0x05, oerr=1, osize_err=0.
- Frame of zeros except symbol index 253 = 0x01 -> S_j = alpha^j: S_0=01, S_1=02, S_2=04, S_7=0x80, S_8=0x1D; oerr=1.
- Valid codeword from the encoder (random data, ival gaps, iclkena toggling), sent back-to-back with a second codeword whose isop follows ieop directly -> two strobes, both with oerr=0, osize_err=0.
- Frame of 200 symbols with ieop, then a frame whose isop arrives mid-frame (restart) -> first frame osize_err=1; the restarted frame produces exactly one strobe with correct syndromes.
- ireset asserted at symbol 100 of a frame, then a fresh all-zero frame -> no strobe for the aborted frame; outputs are 0 after reset; the fresh frame gives oerr=0.
